// File: rtl/star_pkg.sv
// Shared constants and state type for the STAR match-drain path.
package star_pkg;

    localparam int STAR_CAM_LEN = 512;
    localparam int STAR_IDX_W = $clog2(STAR_CAM_LEN);

    typedef enum logic {
        IDLE,
        DRAIN
    } drain_state_t;

endpackage

// File: rtl/star_match_drain_if.sv
// Input vector stream and output index stream of the match drain.
interface star_match_drain_if #(
    parameter int CAM_LEN = 512,
    parameter int IDX_W = 9
);
    logic               in_valid;
    logic               in_ready;
    logic [CAM_LEN-1:0] in_vec;
    logic [IDX_W:0]     in_topk;
    logic               out_valid;
    logic               out_ready;
    logic [IDX_W-1:0]   out_idx;
    logic [IDX_W:0]     out_rank;
    logic               out_last;

    modport master (
        output in_valid, in_vec, in_topk, out_ready,
        input  in_ready, out_valid, out_idx, out_rank, out_last
    );

    modport slave (
        input  in_valid, in_vec, in_topk, out_ready,
        output in_ready, out_valid, out_idx, out_rank, out_last
    );
endinterface

// File: rtl/star_onehot_enc.sv
// OR-tree one-hot to binary encoder with a one-hot validity flag.
module star_onehot_enc #(
    parameter int CAM_LEN = 512,
    parameter int IDX_W = 9
) (
    input  logic [CAM_LEN-1:0] vec,
    output logic [IDX_W-1:0]   idx,
    output logic               is_onehot
);
    // Each index bit is the OR of all rows whose position has that bit set.
    always_comb begin
        idx = '0;
        for (int b = 0; b < IDX_W; b++) begin
            for (int i = 0; i < CAM_LEN; i++) begin
                if (i[b]) idx[b] = idx[b] | vec[i];
            end
        end
    end

    assign is_onehot = (vec != '0) &&
                       ((vec & (vec - CAM_LEN'(1))) == '0);
endmodule

// File: rtl/star_match_drain.sv
// Drains a CAM match vector highest row first via the external find-max.
module star_match_drain
    import star_pkg::*;
#(
    parameter int CAM_LEN = STAR_CAM_LEN,
    parameter int IDX_W = $clog2(CAM_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    star_match_drain_if.slave  bus,
    output logic [CAM_LEN-1:0] or_vec,
    input  logic [CAM_LEN-1:0] lm_vec,
    output logic               done,
    output logic [IDX_W:0]     done_cnt,
    output logic               err
);
    drain_state_t       state;
    logic [CAM_LEN-1:0] pending;
    logic [IDX_W:0]     topk;
    logic [IDX_W:0]     rank;

    logic [IDX_W-1:0]   enc_idx;
    logic               onehot;
    logic               draining;
    logic [CAM_LEN-1:0] remain;
    logic [IDX_W:0]     rank_nx;
    logic               last;
    logic               bad;

    star_onehot_enc #(
        .CAM_LEN(CAM_LEN),
        .IDX_W  (IDX_W)
    ) u_enc (
        .vec      (lm_vec),
        .idx      (enc_idx),
        .is_onehot(onehot)
    );

    assign or_vec   = pending;
    assign draining = (state == DRAIN);
    assign remain   = pending & ~lm_vec;
    assign rank_nx  = rank + (IDX_W+1)'(1);
    assign last     = (remain == '0) ||
                      (topk != '0 && rank_nx == topk);
    // A leading match outside the pending set means find-max is broken.
    assign bad      = draining &&
                      (!onehot || (lm_vec & ~pending) != '0);

    assign bus.in_ready  = !draining;
    assign bus.out_valid = draining;
    assign bus.out_idx   = draining ? enc_idx : '0;
    assign bus.out_rank  = draining ? rank : '0;
    assign bus.out_last  = draining && last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pending  <= '0;
            topk     <= '0;
            rank     <= '0;
            done     <= 1'b0;
            done_cnt <= '0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        pending <= bus.in_vec;
                        topk    <= bus.in_topk;
                        rank    <= '0;
                        if (bus.in_vec == '0) begin
                            done     <= 1'b1;
                            done_cnt <= '0;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (bad) begin
                        err     <= 1'b1;
                        state   <= IDLE;
                        pending <= '0;
                    end else if (bus.out_ready) begin
                        pending <= remain;
                        rank    <= rank_nx;
                        if (last) begin
                            state    <= IDLE;
                            pending  <= '0;
                            done     <= 1'b1;
                            done_cnt <= rank_nx;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
